m65c02_lu_pipe: RTL and testbench

- Parametrised, pipelined logic unit for the M65C02A ALU.
- Covers the TRB/AND/ORA/EOR family, plus RMBx/SMBx bit-mask generation and BIT flag generation.
- Supports a runtime 8-bit/W-bit operand size for the core's wide mode.
- Registered pipeline with a valid/ready handshake so the microsequencer can stall it. It sits beside the adder in the ALU and feeds the result/flag multiplexer.

---
 rtl/m65c02_lu_pipe.sv | 137 +++++++++++++
 tb/tb_m65c02_lu_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/m65c02_lu_pipe.sv
// Pipelined logic unit for the M65C02A ALU: TRB/AND/ORA/EOR, RMB/SMB masks and BIT flags.
// Global-stall valid/ready pipeline; 8-bit or W-bit operand size selected per op.
module m65c02_lu_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En,
  output logic         Ack,
  input  logic [2:0]   Op,
  input  logic         Siz,
  input  logic [2:0]   Bit,
  input  logic [W-1:0] L,
  input  logic [W-1:0] M,
  input  logic         Rdy,
  output logic [W-1:0] Out,
  output logic         Z,
  output logic         N,
  output logic         V,
  output logic         Val
);

  typedef struct packed {
    logic [2:0]   op;
    logic         siz;
    logic [2:0]   bidx;
    logic [W-1:0] l;
    logic [W-1:0] m;
  } req_t;

  logic              adv;
  logic [STAGES:1]   vld_pipe;
  req_t              in_req;
  req_t              cur;
  logic              cur_vld;

  assign adv = ~Val | Rdy;
  assign Ack = adv;
  assign Val = vld_pipe[STAGES];

  // Bubbles carry all-zero data so idle stages never toggle on stale operands.
  always_comb begin
    in_req = '0;
    if (En) in_req = '{op: Op, siz: Siz, bidx: Bit, l: L, m: M};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= En;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  generate
    if (STAGES == 2) begin : g_two
      req_t s1;
      always_ff @(posedge Clk) begin
        if (Rst)      s1 <= '0;
        else if (adv) s1 <= in_req;
      end
      assign cur     = s1;
      assign cur_vld = vld_pipe[1];
    end else begin : g_one
      assign cur     = in_req;
      assign cur_vld = En;
    end
  endgenerate

  logic [7:0]   l8, m8, msk, lo;
  logic         siz_e;
  logic [W-1:0] res;
  logic         rz, rn, rv;

  always_comb begin
    l8    = cur.l[7:0];
    m8    = cur.m[7:0];
    msk   = 8'h01 << cur.bidx;
    siz_e = cur.siz && (W > 8);
    case (cur.op)
      3'b000:  lo = ~l8 & m8;
      3'b001:  lo = l8 & m8;
      3'b010:  lo = l8 | m8;
      3'b011:  lo = l8 ^ m8;
      3'b100:  lo = m8 & ~msk;
      3'b101:  lo = m8 | msk;
      default: lo = m8;
    endcase
    // Z always reflects L&M, as 6502 BIT/TRB/TSB expect, regardless of Op.
    rz = siz_e ? ~|(cur.l & cur.m) : ~|(l8 & m8);
    rn = siz_e ? cur.m[W-1] : m8[7];
    rv = siz_e ? cur.m[W-2] : m8[6];
  end

  generate
    if (W > 8) begin : g_wide
      logic [W-1:0] wide;
      always_comb begin
        case (cur.op)
          3'b000:  wide = ~cur.l & cur.m;
          3'b001:  wide = cur.l & cur.m;
          3'b010:  wide = cur.l | cur.m;
          3'b011:  wide = cur.l ^ cur.m;
          default: wide = {cur.m[W-1:8], lo};
        endcase
      end
      // Byte ops leave the accumulator's upper byte untouched.
      assign res = siz_e ? wide : {cur.l[W-1:8], lo};
    end else begin : g_byte
      assign res = lo;
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Out <= '0;
      Z   <= 1'b0;
      N   <= 1'b0;
      V   <= 1'b0;
    end else if (adv) begin
      if (cur_vld) begin
        Out <= res;
        Z   <= rz;
        N   <= rn;
        V   <= rv;
      end else begin
        Out <= '0;
        Z   <= 1'b0;
        N   <= 1'b0;
        V   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m65c02_lu_pipe.sv
// Bench for m65c02_lu_pipe: one STAGES=1 and one STAGES=2 instance, directed table,
// stall/reset sequences and a randomized run against a per-instance reference model.
module tb_m65c02_lu_pipe;
  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Rst, En, Siz, Rdy1, Rdy2;
  logic [2:0]   Op, Bit;
  logic [W-1:0] L, M;
  logic         Ack1, Val1, Z1, N1, V1;
  logic         Ack2, Val2, Z2, N2, V2;
  logic [W-1:0] Out1, Out2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  m65c02_lu_pipe #(.W(W), .STAGES(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .En(En), .Ack(Ack1), .Op(Op), .Siz(Siz), .Bit(Bit),
    .L(L), .M(M), .Rdy(Rdy1), .Out(Out1), .Z(Z1), .N(N1), .V(V1), .Val(Val1));

  m65c02_lu_pipe #(.W(W), .STAGES(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .En(En), .Ack(Ack2), .Op(Op), .Siz(Siz), .Bit(Bit),
    .L(L), .M(M), .Rdy(Rdy2), .Out(Out2), .Z(Z2), .N(N2), .V(V2), .Val(Val2));

  typedef struct packed {
    logic         val;
    logic [W-1:0] out;
    logic         z;
    logic         n;
    logic         vf;
  } res_t;

  res_t obs1, obs2;
  assign obs1 = {Val1, Out1, Z1, N1, V1};
  assign obs2 = {Val2, Out2, Z2, N2, V2};

  typedef struct {
    logic [2:0]  op;
    logic        siz;
    logic [2:0]  b;
    logic [15:0] l;
    logic [15:0] m;
    logic [15:0] out;
    logic        z;
    logic        n;
    logic        v;
  } vec_t;

  // Reference: whole-word result; byte-size ops then splice the accumulator's upper byte back.
  function automatic res_t ref_lu(input logic [2:0] op, input logic siz, input logic [2:0] b,
                                  input logic [15:0] l, input logic [15:0] m);
    res_t r;
    logic [15:0] full, bitm;
    bitm = 16'd1 << b;
    case (op)
      3'd0:    full = ~l & m;
      3'd1:    full = l & m;
      3'd2:    full = l | m;
      3'd3:    full = l ^ m;
      3'd4:    full = m & ~bitm;
      3'd5:    full = m | bitm;
      default: full = m;
    endcase
    r.val = 1'b1;
    r.out = siz ? full : {l[15:8], full[7:0]};
    r.z   = siz ? ((l & m) == 16'd0) : ((l[7:0] & m[7:0]) == 8'd0);
    r.n   = siz ? m[15] : m[7];
    r.vf  = siz ? m[14] : m[6];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic siz, input logic [2:0] b,
                       input logic [15:0] l, input logic [15:0] m);
    En = 1'b1; Op = op; Siz = siz; Bit = b; L = l; M = m;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vec_t tbl [15];
    res_t rA, rB, rC, nr, q1;
    res_t q2 [2];
    logic a1, a2;

    tbl[0]  = '{3'd0, 1'b0, 3'd0, 16'hAB5A, 16'hC30F, 16'hAB05, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'd1, 1'b0, 3'd0, 16'hAB5A, 16'hC30F, 16'hAB0A, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3'd2, 1'b0, 3'd0, 16'hAB5A, 16'hC30F, 16'hAB5F, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3'd3, 1'b0, 3'd0, 16'hAB5A, 16'hC30F, 16'hAB55, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{3'd6, 1'b1, 3'd0, 16'h00FF, 16'hC000, 16'hC000, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{3'd4, 1'b0, 3'd3, 16'h1200, 16'h12FF, 16'h12F7, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{3'd5, 1'b0, 3'd7, 16'h3400, 16'h1200, 16'h3480, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{3'd1, 1'b1, 3'd0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{3'd3, 1'b1, 3'd0, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{3'd0, 1'b1, 3'd0, 16'h00FF, 16'hFF0F, 16'hFF00, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{3'd4, 1'b1, 3'd0, 16'h0000, 16'hABCD, 16'hABCC, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{3'd5, 1'b1, 3'd2, 16'hFFFF, 16'h5A00, 16'h5A04, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{3'd7, 1'b0, 3'd0, 16'h5500, 16'hAA40, 16'h5540, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{3'd2, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{3'd1, 1'b0, 3'd0, 16'hFF80, 16'h0080, 16'hFF80, 1'b0, 1'b1, 1'b0};

    // Reset held two clocks with live traffic on the inputs.
    Rst = 1'b1; Rdy1 = 1'b1; Rdy2 = 1'b1;
    drive(3'd1, 1'b1, 3'd0, 16'hFFFF, 16'hFFFF);
    tick();
    chk("rst1_d1", 32'(obs1), 32'd0);
    chk("rst1_d2", 32'(obs2), 32'd0);
    tick();
    chk("rst2_d1", 32'(obs1), 32'd0);
    chk("rst2_d2", 32'(obs2), 32'd0);
    Rst = 1'b0; En = 1'b0;
    tick();
    chk("rel_d1", 32'(obs1), 32'd0);
    chk("rel_d2", 32'(obs2), 32'd0);

    // Back-to-back vectors through the single-stage instance.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].op, tbl[i].siz, tbl[i].b, tbl[i].l, tbl[i].m);
      tick();
      chk($sformatf("vec%0d", i), 32'(obs1),
          32'({1'b1, tbl[i].out, tbl[i].z, tbl[i].n, tbl[i].v}));
    end
    En = 1'b0;
    repeat (3) tick();

    // Stall on the two-stage instance with A at the output and B, C behind it.
    rA = ref_lu(3'd1, 1'b1, 3'd0, 16'hF0F0, 16'h0FF0);
    rB = ref_lu(3'd2, 1'b0, 3'd0, 16'h1200, 16'h0034);
    rC = ref_lu(3'd3, 1'b1, 3'd0, 16'hFFFF, 16'h0F0F);
    drive(3'd1, 1'b1, 3'd0, 16'hF0F0, 16'h0FF0);
    tick();
    drive(3'd2, 1'b0, 3'd0, 16'h1200, 16'h0034);
    tick();
    chk("stall_a", 32'(obs2), 32'(rA));
    Rdy2 = 1'b0;
    drive(3'd3, 1'b1, 3'd0, 16'hFFFF, 16'h0F0F);
    #1;
    chk("stall_ack0", 32'(Ack2), 32'd0);
    tick();
    chk("stall_hold1", 32'(obs2), 32'(rA));
    tick();
    chk("stall_hold2", 32'(obs2), 32'(rA));
    chk("stall_ack1", 32'(Ack2), 32'd0);
    Rdy2 = 1'b1;
    #1;
    chk("stall_ack_rel", 32'(Ack2), 32'd1);
    tick();
    En = 1'b0;
    chk("retire_b", 32'(obs2), 32'(rB));
    tick();
    chk("retire_c", 32'(obs2), 32'(rC));
    tick();
    chk("retire_drain", 32'(obs2), 32'd0);

    // Reset with ops in flight: nothing must emerge afterwards.
    drive(3'd2, 1'b1, 3'd0, 16'h1111, 16'h2222);
    tick();
    drive(3'd3, 1'b1, 3'd0, 16'h3333, 16'h4444);
    Rst = 1'b1;
    tick();
    Rst = 1'b0; En = 1'b0;
    chk("midrst", 32'(obs2), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("midrst_drain%0d", i), 32'(obs2), 32'd0);
    end

    // Randomized traffic and backpressure on both instances against the model.
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    q1 = '0; q2[0] = '0; q2[1] = '0;
    for (int i = 0; i < 400; i++) begin
      En   = ($urandom_range(0, 9) < 7);
      Op   = 3'($urandom);
      Siz  = 1'($urandom);
      Bit  = 3'($urandom);
      L    = 16'($urandom);
      M    = 16'($urandom);
      Rdy1 = ($urandom_range(0, 3) != 0);
      Rdy2 = ($urandom_range(0, 3) != 0);
      #1;
      a1 = !q1.val || Rdy1;
      a2 = !q2[1].val || Rdy2;
      chk($sformatf("rnd_ack1_%0d", i), 32'(Ack1), 32'(a1));
      chk($sformatf("rnd_out1_%0d", i), 32'(obs1), 32'(q1));
      chk($sformatf("rnd_ack2_%0d", i), 32'(Ack2), 32'(a2));
      chk($sformatf("rnd_out2_%0d", i), 32'(obs2), 32'(q2[1]));
      nr = En ? ref_lu(Op, Siz, Bit, L, M) : '0;
      if (a1) q1 = nr;
      if (a2) begin
        q2[1] = q2[0];
        q2[0] = nr;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
